// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes, FSM states
// and the elaboration-time check on the UNROLL parameter.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIXUP
  } state_e;

  function automatic bit unroll_legal(input int unsigned width, input int unsigned unroll);
    return (unroll == 1 || unroll == 2 || unroll == 4) && (width % unroll == 0);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiplier (shift-add) or divider (restoring subtract),
// operating on the {hi, lo} accumulator pair.
module mips_muldiv_step
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic           ge;

  // Multiply: lo holds the remaining multiplier bits, product bits shift in from the top.
  assign sum       = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand} : '0);
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign rem_shift = {hi_i, lo_i[WIDTH-1]};
  assign ge        = rem_shift >= {1'b0, operand};

  always_comb begin
    if (is_div) begin
      hi_o = ge ? WIDTH'(rem_shift - {1'b0, operand}) : rem_shift[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO unit: MULT/MULTU/DIV/DIVU over WIDTH/UNROLL cycles plus
// a sign-fixup cycle, and single-cycle MTHI/MTLO writes.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N  = WIDTH / UNROLL;
  localparam int unsigned CW = $clog2(N + 1);

  if (!unroll_legal(WIDTH, UNROLL)) begin : g_bad_unroll
    $error("mips_muldiv_unit: UNROLL must be 1, 2 or 4 and divide WIDTH");
  end

  state_e           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div, neg_q, neg_r, div_zero;
  logic             launch, mt_write, commit;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op && operand_a[WIDTH-1];
  assign b_neg     = signed_op && operand_b[WIDTH-1];
  assign mag_a     = a_neg ? -operand_a : operand_a;
  assign mag_b     = b_neg ? -operand_b : operand_b;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n  = state;
    launch   = 1'b0;
    mt_write = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (op <= 3'd3) begin
            launch  = 1'b1;
            state_n = S_RUN;
          end else if (op == OP_MTHI || op == OP_MTLO) begin
            mt_write = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort)                   state_n = S_IDLE;
        else if (cnt == CW'(N - 1))  state_n = S_FIXUP;
      end
      S_FIXUP: begin
        state_n = S_IDLE;
        commit  = !abort;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          state <= S_IDLE;
    else if (clk_enable) state <= state_n;
  end

  logic [WIDTH-1:0] chain_hi [UNROLL+1];
  logic [WIDTH-1:0] chain_lo [UNROLL+1];

  assign chain_hi[0] = acc_hi;
  assign chain_lo[0] = acc_lo;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .hi_i    (chain_hi[i]),
      .lo_i    (chain_lo[i]),
      .operand (opnd),
      .hi_o    (chain_hi[i+1]),
      .lo_o    (chain_lo[i+1])
    );
  end

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  // Remainder follows the dividend's sign, which also yields hi = operand_a on divide-by-zero.
  assign quo_fix  = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (clk_enable) begin
      done        <= commit;
      div_by_zero <= commit && is_div && div_zero;
      if (launch) begin
        cnt      <= '0;
        is_div   <= op[1];
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= op[1] ? a_neg : (a_neg ^ b_neg);
        div_zero <= (operand_b == '0);
        acc_hi   <= '0;
        acc_lo   <= op[1] ? mag_a : mag_b;
        opnd     <= op[1] ? mag_b : mag_a;
      end else if (state == S_RUN) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= chain_hi[UNROLL];
        acc_lo <= chain_lo[UNROLL];
      end
      if (mt_write) begin
        if (op == OP_MTHI) hi <= operand_a;
        else               lo <= operand_a;
      end
      if (commit) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: randomized and directed HI/LO ops
// checked against an arithmetic reference model.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;
  logic        busy4, done4, dz4;
  logic [31:0] hi4, lo4;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
    .busy(busy), .done(done), .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .abort(abort),
    .busy(busy4), .done(done4), .div_by_zero(dz4), .hi(hi4), .lo(lo4)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic res_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic signed [63:0] sa, sb, p, q, rm;
    logic [63:0] up;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    r.hi = exp_hi;
    r.lo = exp_lo;
    r.dz = 1'b0;
    case (o)
      3'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.dz = 1'b1;
        end else if (o == 3'd2) begin
          q = sa / sb; rm = sa % sb;
          r.hi = rm[31:0]; r.lo = q[31:0];
        end else begin
          r.hi = a % b; r.lo = a / b;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        mon_e = exp_q.pop_front();
        check("mon_hi", {32'b0, hi}, {32'b0, mon_e.hi});
        check("mon_lo", {32'b0, lo}, {32'b0, mon_e.lo});
        check("mon_div_by_zero", {63'b0, dz}, {63'b0, mon_e.dz});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    if (o <= 3'd3) begin
      r = model(o, a, b);
      exp_q.push_back(r);
      exp_hi = r.hi;
      exp_lo = r.lo;
    end else if (o == 3'd4) exp_hi = a;
    else if (o == 3'd5) exp_lo = a;
    @(negedge clk);
    start = 1'b0; operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int c;
    issue(o, a, b);
    wait_idle(c);
    check("busy_cycles", 64'(c), (o <= 3'd3) ? 64'd33 : 64'd0);
    check("done_pulse", {63'b0, done}, {63'b0, (o <= 3'd3)});
    check("hi", {32'b0, hi}, {32'b0, exp_hi});
    check("lo", {32'b0, lo}, {32'b0, exp_lo});
    @(negedge clk);
    check("done_clear", {63'b0, done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c4;
    repeat (3) @(negedge clk);
    check("reset_hi", {32'b0, hi}, 64'd0);
    check("reset_lo", {32'b0, lo}, 64'd0);
    check("reset_busy_done_dz", {61'b0, busy, done, dz}, 64'd0);
    reset = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    check("multu_max_lo", {32'b0, lo}, 64'h0000_0001);
    run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007);
    check("mult_neg_lo", {32'b0, lo}, 64'hFFFF_FFEB);
    run_op(3'd4, 32'h0000_1234, 32'h0);
    check("mthi", {32'b0, hi}, 64'h1234);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(3'd3, 32'h0000_0007, 32'h0000_0000);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);

    // Abort in IDLE swallows a simultaneous start.
    @(negedge clk);
    abort = 1'b1; start = 1'b1; op = 3'd5; operand_a = 32'hDEAD_BEEF;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("idle_abort_busy", {63'b0, busy}, 64'd0);
    check("idle_abort_lo", {32'b0, lo}, {32'b0, exp_lo});

    // Abort on busy cycle 10 with start held high.
    @(negedge clk);
    start = 1'b1; op = 3'd3; operand_a = 32'd100; operand_b = 32'd7;
    repeat (10) @(negedge clk);
    check("busy_before_abort", {63'b0, busy}, 64'd1);
    abort = 1'b1;
    @(negedge clk);
    check("busy_after_abort", {63'b0, busy}, 64'd0);
    abort = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("abort_lo", {32'b0, lo}, {32'b0, exp_lo});

    // Five disabled clocks in the middle of a MULTU.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    c = 0;
    while (busy && c < 200) begin
      c++;
      if (c == 10) clk_enable = 1'b0;
      if (c == 15) clk_enable = 1'b1;
      @(negedge clk);
    end
    check("stall_busy_cycles", 64'(c), 64'd38);
    check("stall_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("stall_lo", {32'b0, lo}, {32'b0, exp_lo});
    @(negedge clk);

    // Asynchronous reset mid-operation.
    issue(3'd0, $urandom, $urandom);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_hi_lo", {hi, lo}, 64'd0);
    check("midreset_busy_done_dz", {61'b0, busy, done, dz}, 64'd0);
    exp_q.delete();
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // UNROLL=4 instance: 8 iterations plus fixup.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    c4 = 0;
    while (busy4 && c4 < 200) begin
      c4++;
      @(negedge clk);
    end
    check("unroll4_busy_cycles", 64'(c4), 64'd9);
    check("unroll4_hi", {32'b0, hi4}, 64'hFFFF_FFFE);
    check("unroll4_lo", {32'b0, lo4}, 64'h0000_0001);
    wait_idle(c);
    check("unroll1_busy_rest", 64'(c), 64'd24);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd(), rnd());
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width in bits.
REQ-002 Parameter UNROLL, default 1: bits retired per iteration; legal values 1, 2, 4; WIDTH SHALL be a multiple of UNROLL (elaboration error otherwise).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 clk_enable  in  1  when low, every register SHALL hold its value.
REQ-006 start  in  1  request; sampled on a rising edge with clk_enable=1.
REQ-007 op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved and SHALL have no effect.
REQ-008 operand_a  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
REQ-009 operand_b  in  WIDTH  rt value (multiplier/divisor).
REQ-010 abort  in  1  pipeline flush; cancels the in-flight operation.
REQ-011 busy  out  1  high while an operation is in flight; decode SHALL stall MFHI/MFLO/MULT/DIV while busy=1.
REQ-012 done  out  1  one-cycle pulse when HI/LO are updated by a completed MULT/DIV.
REQ-013 div_by_zero  out  1  valid with done; high if the completed divide had operand_b=0.
REQ-014 hi, lo  out  WIDTH each  architectural HI/LO registers.

Function
REQ-015 FSM states: IDLE, RUN, FIXUP. Let N = WIDTH/UNROLL.
REQ-016 IDLE + start + op in {0..3} + abort=0: latch magnitudes (signed ops) or raw operands (unsigned ops), record the result signs, clear the iteration counter, go to RUN.
REQ-017 IDLE + start + op in {4,5}: write operand_a to hi (4) or lo (5) on that edge; stay in IDLE; busy and done stay low.
REQ-018 RUN: perform UNROLL shift-add (multiply) or restoring-subtract (divide) steps per enabled cycle; after N enabled cycles go to FIXUP.
REQ-019 FIXUP: apply sign correction, write hi/lo, go to IDLE; done=1 and div_by_zero valid for exactly the following cycle.
REQ-020 busy SHALL be 1 in RUN and FIXUP: N+1 enabled cycles (33 cycles for WIDTH=32, UNROLL=1).
REQ-021 Multiply result: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH-bit product.
REQ-022 Multiply sign rule: the product is negated when the operand signs differ (signed op only).
REQ-023 Divide result: lo = quotient truncated toward zero; hi = remainder taking the dividend's sign.
REQ-024 Divide by zero (DIV or DIVU): still takes N+1 cycles; lo = all ones, hi = operand_a, div_by_zero = 1.
REQ-025 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-026 start while busy=1 SHALL be ignored; no queuing.
REQ-027 abort while busy=1: return to IDLE on the next enabled edge; hi/lo unchanged; no done.
REQ-028 abort in IDLE: no effect, and a start in the same cycle SHALL be ignored.
REQ-029 Operands are captured at start; later changes to operand_a/operand_b SHALL not affect the result.

Reset
REQ-030 reset low SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0 and counter=0 immediately, independent of clk and clk_enable.
REQ-031 Reset mid-operation SHALL discard the operation; the first start after release SHALL behave as from power-up.

Structure
REQ-032 Package mips_muldiv_pkg SHALL hold the op encoding enum, the FSM state enum and the UNROLL legality check.
REQ-033 One combinational sub-module, mips_muldiv_step (one multiply/divide iteration), SHALL be instantiated UNROLL times in a chain.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses 1 cycle.
REQ-035 MULT 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MTHI 0x1234 -> hi=0x1234 next edge, busy stays 0.
REQ-036 DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1 with done.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-038 DIVU started, abort on busy cycle 10, start held high meanwhile -> busy low next cycle, no done, hi/lo keep prior values.
REQ-039 clk_enable low 5 cycles mid-MULTU -> busy lasts 38 clocks with an unchanged result; reset low mid-op -> all outputs 0 at once; repeat REQ-034 with UNROLL=4 -> busy 9 cycles.
